// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// seg_scan_decoder : multiplexed 7-segment bus reader, decodes 4 digits -> hex
// Revision 1.0
// ============================================================================
module seg_scan_decoder #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  an,
   input  logic [6:0]  seg,
   output logic [15:0] value,
   output logic        frame_valid,
   output logic [3:0]  blank_mask,
   output logic [3:0]  seen,
   output logic        err_code,
   output logic        err_anode
);

   localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

   logic [3:0]       meta_an, s_an, p_an;
   logic [6:0]       meta_seg, s_seg, p_seg;
   logic [7:0]       cnt;
   logic [3:0][3:0]  digits, digits_nx;
   logic [3:0]       blank_stage, blank_nx;
   logic [3:0]       seen_nx;
   logic             code_nx, anode_nx;
   logic             same, cap, onehot;
   logic [3:0]       sel;
   logic [1:0]       idx;
   logic [4:0]       dec;

   function automatic logic [4:0] decode(input logic [6:0] s);
      logic [4:0] r;
      case (s)
         7'b1000000: r = {1'b1, 4'h0};
         7'b1111001: r = {1'b1, 4'h1};
         7'b0100100: r = {1'b1, 4'h2};
         7'b0110000: r = {1'b1, 4'h3};
         7'b0011001: r = {1'b1, 4'h4};
         7'b0010010: r = {1'b1, 4'h5};
         7'b0000010: r = {1'b1, 4'h6};
         7'b1111000: r = {1'b1, 4'h7};
         7'b0000000: r = {1'b1, 4'h8};
         7'b0010000: r = {1'b1, 4'h9};
         7'b0001000: r = {1'b1, 4'hA};
         7'b0000011: r = {1'b1, 4'hB};
         7'b1000110: r = {1'b1, 4'hC};
         7'b0100001: r = {1'b1, 4'hD};
         7'b0000110: r = {1'b1, 4'hE};
         7'b0001110: r = {1'b1, 4'hF};
         default:    r = 5'b0_0000;
      endcase
      return r;
   endfunction

   // cnt lags the sample count by one, so cap looks at the value about to saturate
   assign same   = ({s_an, s_seg} == {p_an, p_seg});
   assign cap    = same && (cnt == STABLE_C - 8'd1);
   assign sel    = ~s_an;
   assign onehot = (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
   assign dec    = decode(s_seg);

   always_comb begin
      idx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (sel[i]) idx = 2'(i);
      end
   end

   always_comb begin
      seen_nx   = seen;
      digits_nx = digits;
      blank_nx  = blank_stage;
      code_nx   = 1'b0;
      anode_nx  = 1'b0;
      // completion clears first; a same-cycle capture opens the next frame
      if (seen == 4'hF) seen_nx = 4'h0;
      if (cap && (s_an != 4'hF)) begin
         if (!onehot) begin
            anode_nx = 1'b1;
         end else if (dec[4]) begin
            digits_nx[idx] = dec[3:0];
            blank_nx[idx]  = 1'b0;
            seen_nx[idx]   = 1'b1;
         end else if (s_seg == 7'h7F) begin
            digits_nx[idx] = 4'h0;
            blank_nx[idx]  = 1'b1;
            seen_nx[idx]   = 1'b1;
         end else begin
            code_nx = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta_an     <= 4'hF;
         meta_seg    <= 7'h7F;
         s_an        <= 4'hF;
         s_seg       <= 7'h7F;
         p_an        <= 4'hF;
         p_seg       <= 7'h7F;
         cnt         <= 8'd0;
         digits      <= '0;
         blank_stage <= 4'h0;
         seen        <= 4'h0;
         value       <= 16'h0;
         blank_mask  <= 4'h0;
         frame_valid <= 1'b0;
         err_code    <= 1'b0;
         err_anode   <= 1'b0;
      end else begin
         meta_an  <= an;
         meta_seg <= seg;
         s_an     <= meta_an;
         s_seg    <= meta_seg;
         p_an     <= s_an;
         p_seg    <= s_seg;
         if (!same)
            cnt <= 8'd1;
         else if (cnt != STABLE_C)
            cnt <= cnt + 8'd1;
         digits      <= digits_nx;
         blank_stage <= blank_nx;
         seen        <= seen_nx;
         err_code    <= code_nx;
         err_anode   <= anode_nx;
         frame_valid <= (seen == 4'hF);
         if (seen == 4'hF) begin
            value      <= digits;
            blank_mask <= blank_stage;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// tb_seg_scan_decoder : directed stimulus with an expected-event scoreboard
// Revision 1.0
// ============================================================================
module tb_seg_scan_decoder;

   localparam logic [1:0] K_FRAME = 2'd0;
   localparam logic [1:0] K_CODE  = 2'd1;
   localparam logic [1:0] K_ANODE = 2'd2;

   typedef struct packed {
      logic [1:0]  kind;
      logic [15:0] val;
      logic [3:0]  blank;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  an = 4'hF;
   logic [6:0]  seg = 7'h7F;
   logic [15:0] value;
   logic        frame_valid;
   logic [3:0]  blank_mask;
   logic [3:0]  seen;
   logic        err_code;
   logic        err_anode;

   exp_t q[$];
   int   vectors = 0;
   int   miscompares = 0;

   seg_scan_decoder #(.STABLE_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .an(an), .seg(seg), .value(value),
      .frame_valid(frame_valid), .blank_mask(blank_mask), .seen(seen),
      .err_code(err_code), .err_anode(err_anode)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic pop_check(input logic [1:0] k);
      exp_t e;
      vectors++;
      if (q.size() == 0) begin
         miscompares++;
         $display("FAIL unexpected_event: got kind %0d expected none", k);
      end else begin
         e = q.pop_front();
         if (e.kind != k || (k == K_FRAME && (value !== e.val || blank_mask !== e.blank))) begin
            miscompares++;
            $display("FAIL event: got kind %0d value %h blank %b expected kind %0d value %h blank %b",
                     k, value, blank_mask, e.kind, e.val, e.blank);
         end
      end
   endtask

   // monitor: every output pulse must match the next expected event
   always @(negedge clk) begin
      if (rst_n) begin
         if (err_code && err_anode) begin
            vectors++;
            miscompares++;
            $display("FAIL err_exclusive: got both pulses expected at most one");
         end
         if (frame_valid) pop_check(K_FRAME);
         if (err_code)    pop_check(K_CODE);
         if (err_anode)   pop_check(K_ANODE);
      end
   end

   // entered and left on a negedge; pins held for n rising edges
   task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
      an  = a;
      seg = s;
      repeat (n) @(negedge clk);
   endtask

   task automatic digit(input logic [3:0] a, input logic [6:0] s);
      drive(a, s, 8);
      drive(4'hF, 7'h7F, 2);
   endtask

   task automatic expect_ev(input logic [1:0] k, input logic [15:0] v, input logic [3:0] b);
      exp_t e;
      e.kind = k; e.val = v; e.blank = b;
      q.push_back(e);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("reset_value", value, 16'h0);
      check("reset_blank", {12'h0, blank_mask}, 16'h0);
      check("reset_seen", {12'h0, seen}, 16'h0);
      check("reset_fv", {15'h0, frame_valid}, 16'h0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // full frame 7FA2
      expect_ev(K_FRAME, 16'h7FA2, 4'b0000);
      digit(4'b1110, 7'b0100100);
      digit(4'b1101, 7'b0001000);
      digit(4'b1011, 7'b0001110);
      digit(4'b0111, 7'b1111000);
      check("frame1_seen", {12'h0, seen}, 16'h0);

      // blank digit 2
      expect_ev(K_FRAME, 16'h70A2, 4'b0100);
      digit(4'b1110, 7'b0100100);
      digit(4'b1101, 7'b0001000);
      digit(4'b1011, 7'b1111111);
      digit(4'b0111, 7'b1111000);
      check("frame2_seen", {12'h0, seen}, 16'h0);

      // 3-sample dwell is rejected
      drive(4'b1110, 7'b1111001, 3);
      drive(4'hF, 7'h7F, 8);
      check("glitch_seen", {12'h0, seen}, 16'h0);

      // 4-sample dwell captures: effects after edge k+5
      drive(4'b1110, 7'b1111001, 4);
      drive(4'hF, 7'h7F, 1);
      check("lat_before", {12'h0, seen}, 16'h0);
      @(negedge clk);
      check("lat_after", {12'h0, seen}, 16'h0001);
      repeat (4) @(negedge clk);

      // illegal code on digit 1
      expect_ev(K_CODE, 16'h0, 4'h0);
      drive(4'b1101, 7'b0111111, 10);
      drive(4'hF, 7'h7F, 4);
      check("code_seen", {12'h0, seen}, 16'h0001);

      // anode conflict, pattern 8 must not reach d0/d1
      expect_ev(K_ANODE, 16'h0, 4'h0);
      drive(4'b1100, 7'b0000000, 10);
      drive(4'hF, 7'h7F, 4);
      check("anode_seen", {12'h0, seen}, 16'h0001);

      // finish the frame started by the d0=1 capture
      expect_ev(K_FRAME, 16'h7FA1, 4'b0000);
      digit(4'b1101, 7'b0001000);
      digit(4'b1011, 7'b0001110);
      digit(4'b0111, 7'b1111000);
      check("frame3_seen", {12'h0, seen}, 16'h0);

      // reset mid-frame discards digits 0 and 1
      digit(4'b1110, 7'b0100100);
      digit(4'b1101, 7'b0001000);
      check("mid_seen_pre", {12'h0, seen}, 16'h0003);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      digit(4'b1011, 7'b0001110);
      digit(4'b0111, 7'b1111000);
      check("mid_seen_post", {12'h0, seen}, 16'h000C);
      check("mid_value", value, 16'h0);

      repeat (20) @(negedge clk);
      check("pending_events", 16'(q.size()), 16'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
